// File: rtl/run_len_detector.sv
// Serial-bit run-length detector: flags runs of RUN_LEN+ identical valid bits per enabled polarity.
// All outputs registered; one-cycle latency from sampling edge. No backpressure (x_valid qualifies samples).
module run_len_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             x_valid,
  input  logic             x,
  input  logic [1:0]       mode,
  output logic             y,
  output logic             y_start,
  output logic             run_end,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [CNT_W-1:0] last_len
);

  typedef enum logic [1:0] {IDLE, COUNT, HIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);

  state_t           state, state_nxt;
  logic             bit_nxt, ys_nxt, re_nxt;
  logic [CNT_W-1:0] cnt_nxt, last_nxt, cnt_inc;
  logic             en_cur, en_x;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      run_bit  <= 1'b0;
      run_cnt  <= '0;
      last_len <= '0;
      y_start  <= 1'b0;
      run_end  <= 1'b0;
    end else begin
      state    <= state_nxt;
      run_bit  <= bit_nxt;
      run_cnt  <= cnt_nxt;
      last_len <= last_nxt;
      y_start  <= ys_nxt;
      run_end  <= re_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = run_bit;
    cnt_nxt   = run_cnt;
    last_nxt  = last_len;
    ys_nxt    = 1'b0;
    re_nxt    = 1'b0;
    en_cur    = run_bit ? mode[1] : mode[0];
    en_x      = x ? mode[1] : mode[0];
    cnt_inc   = (run_cnt == CNT_MAX) ? CNT_MAX : run_cnt + 1'b1;

    if (clr) begin
      state_nxt = IDLE;
      bit_nxt   = 1'b0;
      cnt_nxt   = '0;
      last_nxt  = '0;
    end else if (x_valid) begin
      if (state == IDLE) begin
        bit_nxt   = x;
        cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        state_nxt = COUNT;
      end else if (x == run_bit) begin
        cnt_nxt = cnt_inc;
        if (state == HIT) begin
          // Losing the polarity enable drops HIT silently even on a matching sample
          if (!en_cur) state_nxt = COUNT;
        end else if (cnt_inc >= RUN_THR && en_x) begin
          state_nxt = HIT;
          ys_nxt    = 1'b1;
        end
      end else begin
        bit_nxt   = x;
        cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        state_nxt = COUNT;
        if (state == HIT && en_cur) begin
          re_nxt   = 1'b1;
          last_nxt = run_cnt;
        end
      end
    end else if (state == HIT && !en_cur) begin
      state_nxt = COUNT;
    end
  end

  assign y = (state == HIT);

endmodule
